// File: rtl/seq_divider.sv
// Sequential unsigned radix-2 restoring divider with valid/ready handshakes.
// One quotient bit per clock through a single (N+1)-bit carry-select subtractor.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring iteration per clock, counter runs N-1 down to 0
// DONE  | result held on Quotient/Remainder/Dbz until out_ready
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Dbz
);

    localparam int W   = N + 1;
    localparam int BLK = 4;
    localparam int NB  = (W + BLK - 1) / BLK;
    localparam int CW  = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    // Partial remainder never exceeds D-1 < 2^N, so the top bit of R is always
    // zero and is not stored.
    logic [N-1:0]  r_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [CW-1:0] count;

    logic [W-1:0]  op_a, op_b, diff;
    logic [NB-1:0] carry;
    logic          neg;
    logic [N-1:0]  r_nxt, q_nxt;

    assign op_a     = {r_reg, q_reg[N-1]};
    assign op_b     = ~{1'b0, d_reg};
    assign carry[0] = 1'b1;

    // a - b as a + ~b + 1, each block precomputing both carry-in outcomes
    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int LO = g * BLK;
        localparam int BW = (g == NB - 1) ? (W - LO) : BLK;
        if (g < NB - 1) begin : g_mid
            logic [BW:0] s0, s1;
            assign s0 = {1'b0, op_a[LO +: BW]} + {1'b0, op_b[LO +: BW]};
            assign s1 = {1'b0, op_a[LO +: BW]} + {1'b0, op_b[LO +: BW]} + (BW + 1)'(1);
            assign diff[LO +: BW] = carry[g] ? s1[BW-1:0] : s0[BW-1:0];
            assign carry[g+1]     = carry[g] ? s1[BW] : s0[BW];
        end else begin : g_top
            logic [BW-1:0] s0, s1;
            assign s0 = op_a[LO +: BW] + op_b[LO +: BW];
            assign s1 = op_a[LO +: BW] + op_b[LO +: BW] + BW'(1);
            assign diff[LO +: BW] = carry[g] ? s1 : s0;
        end
    end

    assign neg   = diff[N];
    assign r_nxt = neg ? op_a[N-1:0] : diff[N-1:0];
    assign q_nxt = {q_reg[N-2:0], ~neg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Dbz       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg <= Dividend;
                        d_reg <= Divisor;
                        r_reg <= '0;
                        count <= CW'(N - 1);
                        if (Divisor == '0) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            Dbz       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_nxt;
                    q_reg <= q_nxt;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        Quotient  <= q_nxt;
                        Remainder <= r_nxt;
                        Dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (Divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (count == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8): directed cases, backpressure,
// mid-operation reset and a random regression against a reference model.
module tb_seq_divider;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] Dividend = '0;
    logic [N-1:0] Divisor = '0;
    logic         in_ready, out_valid, Dbz;
    logic [N-1:0] Quotient, Remainder;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    seq_divider #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Dividend(Dividend), .Divisor(Divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .Quotient(Quotient), .Remainder(Remainder), .Dbz(Dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int stall, input bit poke);
        exp_t e;
        int   lat;
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", in_ready, 1);
        e.q   = (b == 0) ? '1 : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.dbz = (b == 0);
        e.lat = (b == 0) ? 1 : N + 1;
        sb.push_back(e);
        in_valid = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(negedge clk);
        lat = 1;
        in_valid = poke;
        Dividend = N'($urandom);
        Divisor  = N'($urandom);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (poke) begin
                Dividend = N'($urandom);
                Divisor  = N'($urandom);
            end
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("quotient", Quotient, e.q);
        check("remainder", Remainder, e.r);
        check("dbz", Dbz, e.dbz);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_quotient", Quotient, e.q);
            check("stall_remainder", Remainder, e.r);
            check("stall_dbz", Dbz, e.dbz);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", Quotient, 0);
        check("rst_remainder", Remainder, 0);
        check("rst_dbz", Dbz, 0);

        do_op(8'd100, 8'd7, 0, 0);
        do_op(8'd255, 8'd1, 0, 0);
        do_op(8'd255, 8'd255, 0, 0);
        do_op(8'd5, 8'd9, 0, 0);
        do_op(8'd0, 8'd3, 0, 0);
        do_op(8'd37, 8'd0, 0, 0);
        do_op(8'd20, 8'd6, 0, 0);
        do_op(8'd200, 8'd13, 5, 1);

        // reset during the 4th CALC cycle of 100/7
        in_valid = 1'b1;
        Dividend = 8'd100;
        Divisor  = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_quotient", Quotient, 0);
        check("mid_rst_remainder", Remainder, 0);
        check("mid_rst_dbz", Dbz, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", seen, 0);
        do_op(8'd9, 8'd4, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a, b;
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            do_op(a, b, int'($urandom_range(0, 3)), 0);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned radix-2 restoring divider. It is the inverse datapath to the Booth multiplier in booth_mul.
- Computes one quotient bit per clock using a single N+1-bit subtractor, built from carry-select adder blocks in the same style as the multiplier's adders.
- Uses valid/ready handshakes on both the operand side and the result side, so it can sit next to the multiplier in the arithmetic unit.

Parameters:
- N, default 8: operand width in bits. Dividend, divisor, quotient and remainder are all N bits. Legal range is N ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_valid  input  1  operands on Dividend/Divisor are valid.
- in_ready  output  1  block can accept operands.
- Dividend  input  N  unsigned dividend.
- Divisor  input  N  unsigned divisor.
- out_valid  output  1  Quotient/Remainder/Dbz are valid.
- out_ready  input  1  consumer accepts the result.
- Quotient  output  N  unsigned quotient.
- Remainder  output  N  unsigned remainder.
- Dbz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, Quotient=0, Remainder=0, Dbz=0, iteration counter=0.
- Reset overrides everything, including a computation in progress and a held result. Any in-flight operation is discarded and produces no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1:
    - Capture Dividend into the working quotient register Q and Divisor into register D.
    - Clear the partial remainder register R (N+1 bits).
    - Set counter=N−1.
    - If Divisor=0, go to DONE with Quotient={N{1'b1}}, Remainder=Dividend, Dbz=1.
    - Otherwise go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge:
    - T = {R[N−1:0], Q[N−1]} − {1'b0, D}, computed at N+1 bits.
    - If T is non-negative (MSB=0): R←T, Q←{Q[N−2:0], 1}.
    - Else: R←{R[N−1:0], Q[N−1]}, Q←{Q[N−2:0], 0}.
    - counter←counter−1.
  - On the edge where counter=0 (the N-th iteration), go to DONE and register Quotient=new Q, Remainder=new R[N−1:0], Dbz=0.
- DONE:
  - out_valid=1, in_ready=0.
  - Quotient, Remainder and Dbz are held stable for as long as out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - A new operand is not accepted on that same edge; in_ready rises the following cycle.
- Latency, counted from the accepting edge:
  - Normal divide: out_valid is high after N edges of CALC, i.e. N+1 edges after acceptance.
  - Divide-by-zero: out_valid is high after 1 edge.
- Throughput: one division per N+2 cycles minimum, with out_ready held high.
- Arithmetic:
  - Result satisfies Dividend = Quotient·Divisor + Remainder, with Remainder < Divisor.
  - The subtractor is N+1 bits wide, so D up to 2^N−1 never overflows.
- Input stability: Dividend and Divisor are don't-care outside the accepting edge. Changing them during CALC has no effect.
- Outputs Quotient/Remainder/Dbz:
  - Registered, updated only on entry to DONE or on reset.
  - Keep their last value in IDLE and CALC.
- in_valid while busy: ignored in CALC and DONE; no queuing.

Test Plan (N=8):
- Basic divide: accept Dividend=100, Divisor=7. out_valid rises 9 edges after acceptance, with Quotient=14, Remainder=2, Dbz=0.
- Edge values:
  - 255/1 → Q=255, R=0.
  - 255/255 → Q=1, R=0.
  - 5/9 → Q=0, R=5.
  - 0/3 → Q=0, R=0.
- Divide-by-zero: 37/0. out_valid is high 1 edge after acceptance, with Quotient=0xFF, Remainder=37, Dbz=1. The next normal operation 20/6 gives Q=3, R=2, Dbz=0.
- Backpressure and busy inputs:
  - With 200/13, hold out_ready=0 for 5 cycles after out_valid. Q=15 and R=5 must stay stable throughout, and in_ready must stay 0.
  - Pulse in_valid with other operands during CALC and DONE; they must be ignored.
  - Raise out_ready: out_valid drops on the next edge, and in_ready=1 one cycle after that.
- Reset mid-operation: assert rst_n=0 for 1 edge during the 4th CALC cycle of 100/7. The next cycle shows the full reset state and no out_valid pulse. A subsequent 9/4 returns Q=2, R=1.
- Random regression: 1000 random operand pairs, including Divisor=0, with random out_ready stalls. Check every result against a reference model, and check latency equals N+1 edges, or 1 edge when Divisor=0.
